// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its microprogrammed sequencer:
// opcode values, datapath widths and the sequencer state encoding.
package alu_pkg;

  localparam int DW    = 8;
  localparam int PC_W  = 4;
  localparam int INS_W = 16;

  localparam logic [3:0] ADDAB = 4'b0000;
  localparam logic [3:0] INCA  = 4'b0001;
  localparam logic [3:0] INCB  = 4'b0010;
  localparam logic [3:0] ANDAB = 4'b0011;
  localparam logic [3:0] ORAB  = 4'b0100;
  localparam logic [3:0] NEGA  = 4'b0101;
  localparam logic [3:0] SHAL  = 4'b0110;
  localparam logic [3:0] SHAR  = 4'b0111;
  localparam logic [3:0] PASSA = 4'b1000;
  localparam logic [3:0] PASSB = 4'b1001;
  localparam logic [3:0] LDI   = 4'b1010;
  localparam logic [3:0] HALT  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= PASSB;
  endfunction

endpackage

// File: rtl/alu_sequencer_prog_ram.sv
// Program store: 16x16 single write port, registered read port.
// The array is never reset so a loaded program survives rst_n; only the read register clears.
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Microprogrammed controller for the 8-bit ALU: fetches from prog_ram, registers
// operands/opsel toward the ALU, writes results back to a 4x8 register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int DW         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [15:0]                   prog_data,
  input  logic                          start,
  output logic [DW-1:0]                 alu_a,
  output logic [DW-1:0]                 alu_b,
  output logic [3:0]                    alu_opsel,
  input  logic [DW-1:0]                 alu_f,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  input  logic [1:0]                    rd_sel,
  output logic [DW-1:0]                 rd_data,
  output seq_state_t                    fsm_state
);

  localparam int AW = $clog2(PROG_DEPTH);

  logic [15:0]   ir;
  logic [DW-1:0] regs [4];
  logic [3:0]    op;
  logic [1:0]    dst, ra, rb;
  logic [7:0]    imm;
  logic          last_pc;
  logic          ram_we;

  assign op      = ir[15:12];
  assign dst     = ir[11:10];
  assign ra      = ir[9:8];
  assign rb      = ir[7:6];
  assign imm     = ir[7:0];
  assign last_pc = (pc == AW'(PROG_DEPTH - 1));
  assign rd_data = regs[rd_sel];

  // Host writes only land while the sequencer is idle; a running program cannot be altered.
  assign ram_we = prog_we && (fsm_state == S_IDLE);

  // The RAM read register doubles as the instruction register, loaded during FETCH.
  prog_ram #(.DEPTH(PROG_DEPTH), .AW(AW), .WW(16)) u_prog_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (fsm_state == S_FETCH),
    .raddr (pc),
    .rdata (ir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= S_IDLE;
      pc        <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_opsel <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (fsm_state)
        S_IDLE: begin
          if (start) begin
            pc        <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            fsm_state <= S_FETCH;
          end
        end
        S_FETCH: fsm_state <= S_EXEC;
        S_EXEC: begin
          if (is_alu_op(op)) begin
            alu_opsel <= op;
            alu_a     <= regs[ra];
            alu_b     <= regs[rb];
            fsm_state <= S_WB;
          end else if (op == LDI) begin
            regs[dst] <= imm;
            if (last_pc) begin
              done      <= 1'b1;
              fsm_state <= S_DONE;
            end else begin
              pc        <= pc + AW'(1);
              fsm_state <= S_FETCH;
            end
          end else begin
            if (op != HALT) err <= 1'b1;
            done      <= 1'b1;
            fsm_state <= S_DONE;
          end
        end
        S_WB: begin
          regs[dst] <= alu_f;
          if (last_pc) begin
            done      <= 1'b1;
            fsm_state <= S_DONE;
          end else begin
            pc        <= pc + AW'(1);
            fsm_state <= S_FETCH;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          fsm_state <= S_IDLE;
        end
        default: fsm_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a behavioural model of the team ALU.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic [3:0]  alu_opsel;
  logic        busy, done, err;
  logic [3:0]  pc;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  seq_state_t  fsm_state;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cyc;

  alu_sequencer #(.PROG_DEPTH(16), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opsel (alu_opsel),
    .alu_f     (alu_f),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc        (pc),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team ALU behaviour
  function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADDAB:   return a + b;
      INCA:    return a + 8'd1;
      INCB:    return b + 8'd1;
      ANDAB:   return a & b;
      ORAB:    return a | b;
      NEGA:    return 8'd0 - a;
      SHAL:    return {a[6:0], 1'b0};
      SHAR:    return {1'b0, a[7:1]};
      PASSA:   return a;
      PASSB:   return b;
      default: return 8'd0;
    endcase
  endfunction

  always_comb alu_f = alu_model(alu_opsel, alu_a, alu_b);

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
    return {op, d, a, b, 6'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] d, input logic [7:0] imm);
    return {LDI, d, imm[7:6] == 2'b00 ? 2'b00 : 2'b00, imm};
  endfunction

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [1:0] r, input logic [7:0] exp, input string tag);
    rd_sel = r;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  // Drivers
  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic run_prog(input bit disturb, input int rst_at, output int dcyc);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc  = 1;
    dcyc = 0;
    check("busy_cycle1", 32'(busy), 32'd1);
    check("err_cycle1", 32'(err), 32'd0);
    while (cyc < 64) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (rst_at == cyc) begin
        rst_n = 1'b0;
        break;
      end
      if (disturb && cyc == 3) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = ldi(2'd0, 8'hEE);
      end
      if (disturb && cyc == 4) begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      @(negedge clk);
      cyc = cyc + 1;
    end
  endtask

  task automatic load_add_prog();
    load(4'd0, ldi(2'd0, 8'd5));
    load(4'd1, ldi(2'd1, 8'd3));
    load(4'd2, ins(ADDAB, 2'd2, 2'd0, 2'd1));
    load(4'd3, ins(HALT, 2'd0, 2'd0, 2'd0));
  endtask

  // Stimulus
  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; rd_sel = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_alu", {alu_opsel, alu_a, alu_b}, 32'd0);
    check("rst_flags", {busy, done, err}, 32'd0);
    check_reg(2'd3, 8'd0, "rst_r3");
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: 5 + 3
    load_add_prog();
    run_prog(1'b0, -1, done_cyc);
    check("t1_done_cycle", 32'(done_cyc), 32'd10);
    check("t1_busy_in_done", 32'(busy), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_pc", 32'(pc), 32'd3);
    check("t1_alu_a", 32'(alu_a), 32'h05);
    check("t1_alu_b", 32'(alu_b), 32'h03);
    check_reg(2'd2, 8'd8, "t1_r2");
    check_reg(2'd0, 8'd5, "t1_r0");
    check_reg(2'd1, 8'd3, "t1_r1");
    @(negedge clk);
    check("t1_done_pulse_end", 32'(done), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_idle", 32'(fsm_state), 32'(S_IDLE));

    // Test 2: shifts of 0x81
    load(4'd0, ldi(2'd0, 8'h81));
    load(4'd1, ins(SHAL, 2'd1, 2'd0, 2'd0));
    load(4'd2, ins(SHAR, 2'd2, 2'd0, 2'd0));
    load(4'd3, ins(HALT, 2'd0, 2'd0, 2'd0));
    run_prog(1'b0, -1, done_cyc);
    check("t2_done_cycle", 32'(done_cyc), 32'd11);
    check("t2_opsel", 32'(alu_opsel), 32'(SHAR));
    check_reg(2'd1, 8'h02, "t2_r1");
    check_reg(2'd2, 8'h40, "t2_r2");

    // Test 3: sixteen LDIs, no HALT, no wrap
    for (int i = 0; i < 16; i++) load(4'(i), ldi(2'(i % 4), 8'(8'h10 + i)));
    run_prog(1'b0, -1, done_cyc);
    check("t3_done_cycle", 32'(done_cyc), 32'd33);
    check("t3_pc", 32'(pc), 32'd15);
    check_reg(2'd0, 8'h1C, "t3_r0");
    check_reg(2'd1, 8'h1D, "t3_r1");
    check_reg(2'd2, 8'h1E, "t3_r2");
    check_reg(2'd3, 8'h1F, "t3_r3");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t3_no_wrap_state", 32'(fsm_state), 32'(S_IDLE));
    check("t3_no_wrap_pc", 32'(pc), 32'd15);
    check("t3_busy_end", 32'(busy), 32'd0);

    // Test 4: illegal opcode after LDI r0,7
    load(4'd0, ldi(2'd0, 8'd7));
    load(4'd1, ins(4'b1100, 2'd1, 2'd2, 2'd3));
    run_prog(1'b0, -1, done_cyc);
    check("t4_done_cycle", 32'(done_cyc), 32'd5);
    check("t4_err", 32'(err), 32'd1);
    check("t4_pc", 32'(pc), 32'd1);
    check("t4_opsel_held", 32'(alu_opsel), 32'(SHAR));
    check_reg(2'd0, 8'h07, "t4_r0");
    check_reg(2'd1, 8'h1D, "t4_r1");
    check_reg(2'd2, 8'h1E, "t4_r2");
    @(negedge clk);
    @(negedge clk);
    check("t4_err_held", 32'(err), 32'd1);
    check("t4_done_low", 32'(done), 32'd0);
    run_prog(1'b0, -1, done_cyc);
    check("t4b_done_cycle", 32'(done_cyc), 32'd5);

    // Test 5: start and prog_we during a run are ignored
    load_add_prog();
    run_prog(1'b1, -1, done_cyc);
    check("t5_done_cycle", 32'(done_cyc), 32'd10);
    check("t5_err", 32'(err), 32'd0);
    check_reg(2'd2, 8'd8, "t5_r2");
    check_reg(2'd0, 8'd5, "t5_r0");
    run_prog(1'b0, -1, done_cyc);
    check("t5b_done_cycle", 32'(done_cyc), 32'd10);
    check_reg(2'd0, 8'd5, "t5b_r0");

    // Test 6: reset during WB of ADDAB
    run_prog(1'b0, 7, done_cyc);
    #1;
    check("t6_state", 32'(fsm_state), 32'(S_IDLE));
    check("t6_pc", 32'(pc), 32'd0);
    check("t6_alu", {alu_opsel, alu_a, alu_b}, 32'd0);
    check("t6_flags", {busy, done, err}, 32'd0);
    check_reg(2'd0, 8'd0, "t6_r0");
    check_reg(2'd2, 8'd0, "t6_r2");
    @(negedge clk);
    @(negedge clk);
    check("t6_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_prog(1'b0, -1, done_cyc);
    check("t6_rerun_done_cycle", 32'(done_cyc), 32'd10);
    check_reg(2'd2, 8'd8, "t6_rerun_r2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Microprogrammed controller that drives the team's 8-bit ALU (opsel codes 0000–1001) from a small loadable program. It holds a 16-entry program RAM and a 4×8-bit register file, fetches instructions and presents registered operands and opsel to the ALU. It writes the ALU result back, sits directly in front of the ALU, and reports completion to the host with a done/err handshake.

## Interface
- PROG_DEPTH, 16, program RAM entries (pc width 4)
- DW, 8, datapath width (must match ALU)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- prog_we  in  1  program RAM write strobe
- prog_addr  in  4  program RAM write address
- prog_data  in  16  instruction word
- start  in  1  begin execution at pc=0
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_opsel  out  4  registered ALU opcode
- alu_f  in  8  ALU result, combinational from alu_a/alu_b/alu_opsel
- busy  out  1  high from accepted start until DONE state exits
- done  out  1  one-cycle pulse when program ends
- err  out  1  illegal opcode seen; held until next accepted start
- pc  out  4  current program counter
- rd_sel  in  2  debug register select
- rd_data  out  8  R[rd_sel], combinational

## Operation
- Instruction: [15:12] op, [11:10] dst, [9:8] ra, [7:6] rb, [7:0] imm (LDI only; overlaps ra/rb).
- op 0000–1001: ALU op, R[dst] <= ALU(op, R[ra], R[rb]).
- op 1010 LDI: R[dst] <= imm.
- op 1111 HALT: end program.
- op 1011–1110: illegal; err <= 1, end program, no register write.
- FSM states: IDLE, FETCH, EXEC, WB, DONE.
- IDLE: start=1 -> pc<=0, err<=0, busy<=1, FETCH. Otherwise stay.
- FETCH: ir <= prog[pc] (synchronous read) -> EXEC.
- EXEC: ALU op -> alu_opsel<=op, alu_a<=R[ra], alu_b<=R[rb], then WB. LDI -> write, then advance. HALT or illegal -> DONE.
- WB: R[dst] <= alu_f, then advance.
- Advance: pc==15 -> DONE (no wrap). Else pc<=pc+1, FETCH.
- DONE: done=1, busy=0 on exit, then IDLE.
- start while not IDLE: ignored.
- prog_we while busy: ignored (write dropped). In IDLE: writes prog[prog_addr] on the clock edge.
- alu_a/alu_b/alu_opsel hold their last values outside EXEC.

## Timing
- Reset values: state IDLE; alu_a, alu_b, alu_opsel, pc, R0–R3, ir = 0; busy, done, err = 0. Program RAM is not reset; its contents are preserved across rst_n.
- Reset mid-run: immediate abort to IDLE with the above values; no done pulse.
- Cycles per instruction: ALU op 3 (FETCH, EXEC, WB); LDI 2; HALT/illegal 2 plus 1 DONE.
- alu_f is sampled in WB, one full cycle after the operands are registered; ALU combinational path must fit one cycle.
- done is high exactly while in DONE and is never high for more than one cycle.
- Register reads in EXEC see writes from the previous instruction (write completes before the next FETCH), so there is no hazard.

## Structure
- Package alu_pkg holds opcode localparams ADDAB, INCA, INCB, ANDAB, ORAB, NEGA, SHAL, SHAR, PASSA, PASSB (0000–1001), LDI (1010) and HALT (1111), plus the FSM state encoding, shared with the ALU.
- Sub-module prog_ram: 16×16, one write port, one synchronous read port, no reset.
- Register file and FSM stay in alu_sequencer.
- Bench instantiates alu_sequencer connected to the team's ALU.

## Test plan
- Load LDI r0,5; LDI r1,3; ADDAB r2=r0+r1; HALT; start -> R2=8; done high in the 10th cycle counting the first FETCH as 1; err=0.
- LDI r0,0x81; SHAL r1=r0; SHAR r2=r0; HALT -> R1=0x02, R2=0x40.
- Program of 16 LDIs, no HALT -> pc reaches 15, DONE follows without wrap; R[dst] holds last imm.
- op 1100 at addr 1 after LDI r0,7 -> err=1, done pulse, R0=7, other regs unchanged; next start clears err.
- start and prog_we asserted during run -> no restart, program RAM unchanged (verified by rerun result).
- rst_n low during WB of ADDAB -> all outputs/regs 0, busy=0, no done; program RAM intact, rerun gives the same result.
